// File: rtl/string_match_pkg.sv
// Shared defaults, FSM state type and width helpers for the string-match reporting path.
package string_match_pkg;

  localparam int N_DEFAULT = 16;
  localparam int M_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One extra code beyond the legal match count so the full count always fits.
  function automatic int cnt_width(input int n, input int m);
    return $clog2(n - m + 2);
  endfunction

endpackage

// File: rtl/match_prio_enc.sv
// Lowest-set-bit priority encoder; also flags when exactly one bit is set.
module match_prio_enc #(
  parameter int W  = 16,
  parameter int IW = 4
) (
  input  logic [W-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_onehot
);

  logic [W-1:0] w_rest;

  // Scan from the top down so the lowest set position is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IW'(i);
      end else begin
        o_idx = o_idx;
      end
    end
  end

  assign w_rest   = i_vec & (i_vec - W'(1));
  assign o_onehot = (i_vec != '0) && (w_rest == '0);

endmodule

// File: rtl/match_reporter.sv
// Serialises a per-position match flag vector into a stream of matching text indices.
module match_reporter
  import string_match_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int M  = M_DEFAULT,
  parameter int IW = idx_width(N),
  parameter int CW = cnt_width(N, M)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [0:N-1]  flag_in,
  input  logic          flag_valid,
  output logic          flag_ready,
  output logic [IW-1:0] idx_out,
  output logic          idx_valid,
  input  logic          idx_ready,
  output logic          idx_last,
  output logic [CW-1:0] match_count,
  output logic          done,
  output logic          none_found
);

  state_t        r_state;
  logic [N-1:0]  r_mask;
  logic [CW-1:0] r_count;
  logic [N-1:0]  w_masked;
  logic [IW-1:0] w_idx;
  logic          w_onehot;

  // Positions too close to the end of the text cannot start a full-length match.
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < N; i++) begin
      if (i <= N - M) begin
        w_masked[i] = flag_in[i];
      end else begin
        w_masked[i] = 1'b0;
      end
    end
  end

  match_prio_enc #(
    .W  (N),
    .IW (IW)
  ) u_prio_enc (
    .i_vec    (r_mask),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  // Capture / emit / done sequencing; enable low freezes everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_count <= '0;
    end else if (enable) begin
      case (r_state)
        IDLE: begin
          if (flag_valid) begin
            r_mask  <= w_masked;
            r_count <= '0;
            r_state <= (w_masked != '0) ? EMIT : DONE;
          end
        end
        EMIT: begin
          if (idx_ready) begin
            r_mask[w_idx] <= 1'b0;
            r_count       <= r_count + CW'(1);
            if (w_onehot) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign flag_ready  = (r_state == IDLE);
  assign idx_valid   = (r_state == EMIT);
  assign idx_out     = w_idx;
  assign idx_last    = (r_state == EMIT) && w_onehot;
  assign match_count = r_count;
  assign done        = (r_state == DONE);
  assign none_found  = (r_state == DONE) && (r_count == '0);

endmodule

// File: tb/tb_match_reporter.sv
// Self-checking bench: directed vectors plus randomized traffic against a queue-based index model.
module tb_match_reporter;

  localparam int N  = 16;
  localparam int M  = 4;
  localparam int IW = 4;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [0:N-1]  flag_in;
  logic          flag_valid;
  logic          flag_ready;
  logic [IW-1:0] idx_out;
  logic          idx_valid;
  logic          idx_ready;
  logic          idx_last;
  logic [CW-1:0] match_count;
  logic          done;
  logic          none_found;

  int n_checks = 0;
  int n_errors = 0;

  match_reporter #(.N(N), .M(M), .IW(IW), .CW(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .flag_in     (flag_in),
    .flag_valid  (flag_valid),
    .flag_ready  (flag_ready),
    .idx_out     (idx_out),
    .idx_valid   (idx_valid),
    .idx_ready   (idx_ready),
    .idx_last    (idx_last),
    .match_count (match_count),
    .done        (done),
    .none_found  (none_found)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: always ready; 1: random ready/enable + junk flags; 2: ready low 3 cycles; 3: enable low 4 cycles
  task automatic run_vec(input logic [0:N-1] vec, input int mode);
    int exp_q[$];
    int n, k, cyc;
    logic rdy, en;
    for (int p = 0; p <= N - M; p++) begin
      if (vec[p]) exp_q.push_back(p);
    end
    n = exp_q.size();
    chk("flag_ready_idle", flag_ready, 1);
    flag_in    = vec;
    flag_valid = 1'b1;
    enable     = 1'b1;
    idx_ready  = 1'b0;
    @(negedge clock);
    flag_valid = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 200) begin
      chk("idx_valid", idx_valid, 1);
      chk("idx_out", idx_out, exp_q[k]);
      chk("idx_last", idx_last, (k == n - 1) ? 1 : 0);
      chk("count_emit", match_count, k);
      chk("flag_ready_busy", flag_ready, 0);
      chk("done_in_emit", done, 0);
      case (mode)
        1: begin
          rdy = ($urandom_range(0, 1) == 1);
          en  = ($urandom_range(0, 3) != 0);
        end
        2: begin
          rdy = (cyc >= 3);
          en  = 1'b1;
        end
        3: begin
          rdy = 1'b1;
          en  = !(cyc >= 1 && cyc < 5);
        end
        default: begin
          rdy = 1'b1;
          en  = 1'b1;
        end
      endcase
      idx_ready = rdy;
      enable    = en;
      if (mode == 1) begin
        flag_valid = ($urandom_range(0, 1) == 1);
        flag_in    = N'($urandom);
      end
      @(negedge clock);
      if (rdy && en) k++;
      cyc++;
    end
    if (k < n) chk("emit_timeout", k, n);
    flag_valid = 1'b0;
    idx_ready  = 1'b0;
    enable     = 1'b1;
    chk("done", done, 1);
    chk("none_found", none_found, (n == 0) ? 1 : 0);
    chk("count_done", match_count, n);
    chk("idx_valid_done", idx_valid, 0);
    @(negedge clock);
    chk("done_pulse_end", done, 0);
    chk("none_found_end", none_found, 0);
    chk("count_hold", match_count, n);
    chk("flag_ready_after", flag_ready, 1);
    chk("idx_valid_idle", idx_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [0:N-1] v;
    reset      = 1'b0;
    enable     = 1'b0;
    flag_valid = 1'b0;
    flag_in    = '0;
    idx_ready  = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_idx_valid", idx_valid, 0);
    chk("rst_idx_out", idx_out, 0);
    chk("rst_idx_last", idx_last, 0);
    chk("rst_count", match_count, 0);
    chk("rst_done", done, 0);
    chk("rst_none_found", none_found, 0);
    reset  = 1'b1;
    enable = 1'b1;
    @(negedge clock);
    chk("post_rst_flag_ready", flag_ready, 1);
    chk("post_rst_done", done, 0);

    run_vec(16'b1000_0000_0000_1000, 0);
    run_vec(16'b0000_0000_0000_0111, 0);
    run_vec(16'b1111_1111_1111_1000, 0);
    run_vec(16'b0010_0000_0100_0000, 2);
    run_vec(16'b1010_0000_1000_1000, 3);
    run_vec(16'b0000_0000_0000_0000, 1);

    // Reset in the middle of reporting: vector holds positions 0,1,2,5.
    flag_in    = 16'b1110_0100_0000_0000;
    flag_valid = 1'b1;
    @(negedge clock);
    flag_valid = 1'b0;
    idx_ready  = 1'b1;
    repeat (2) @(negedge clock);
    chk("pre_rst_idx", idx_out, 2);
    chk("pre_rst_count", match_count, 2);
    idx_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_idx_valid", idx_valid, 0);
    chk("mid_rst_idx_out", idx_out, 0);
    chk("mid_rst_idx_last", idx_last, 0);
    chk("mid_rst_count", match_count, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_none_found", none_found, 0);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("after_rst_no_done", done, 0);
      chk("after_rst_idx_valid", idx_valid, 0);
      chk("after_rst_flag_ready", flag_ready, 1);
    end

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: v = N'($urandom) & N'($urandom) & N'($urandom);
        1: v = '0;
        default: v = N'($urandom);
      endcase
      run_vec(v, (t % 3 == 0) ? 0 : 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/match_reporter.md
MATCH_REPORTER -- requirements
Module: match_reporter

Interface
REQ-001 Parameters SHALL be:
  - N, default 16, text length in bits.
  - M, default 4, pattern length in bits.
  - IW, default $clog2(N), index width.
  - CW, default $clog2(N-M+2), count width.
REQ-002 Ports SHALL be, in this order:
  - clock  in  1  single clock; all state changes on its rising edge.
  - reset  in  1  asynchronous, active-low reset.
  - enable  in  1  global advance; low freezes all state and outputs.
  - flag_in  in  [0:N-1]  per-position match flags from the string matcher; bit 0 is text position 0.
  - flag_valid  in  1  flag_in is valid this cycle.
  - flag_ready  out  1  block can accept a flag vector.
  - idx_out  out  IW  matching text position being reported.
  - idx_valid  out  1  idx_out is valid.
  - idx_ready  in  1  downstream accepts idx_out.
  - idx_last  out  1  idx_out is the final match of the current vector.
  - match_count  out  CW  number of indices reported for the current vector.
  - done  out  1  one-cycle pulse when a vector is fully reported.
  - none_found  out  1  one-cycle pulse, coincident with done, when the vector had no legal match.

Function
REQ-003 A flag vector transfer SHALL occur on a rising edge where flag_valid, flag_ready and enable are all 1.
REQ-004 On transfer, the block SHALL capture flag_in into an internal mask, forcing positions N-M+1..N-1 to 0 (no legal match there).
REQ-005 The FSM SHALL have exactly three states: IDLE, EMIT, DONE.
REQ-006 In IDLE, flag_ready SHALL be 1; in EMIT and DONE it SHALL be 0.
REQ-007 IDLE transitions:
  - transfer with a nonzero masked vector -> EMIT;
  - transfer with a zero masked vector -> DONE.
REQ-008 In EMIT, idx_valid SHALL be 1 and idx_out SHALL equal the lowest set position in the remaining mask, combinationally from registered state.
REQ-009 idx_last SHALL be 1 in EMIT exactly when the remaining mask has one bit set.
REQ-010 On an idx handshake (idx_valid & idx_ready & enable), the block SHALL:
  - clear the reported bit;
  - increment match_count;
  - go to DONE if idx_last was 1, else stay in EMIT.
REQ-011 While idx_valid=1 and idx_ready=0, idx_out, idx_last and match_count SHALL hold stable.
REQ-012 DONE SHALL last exactly one cycle:
  - done=1;
  - none_found=1 if match_count=0;
  - next state IDLE.
REQ-013 match_count SHALL reset to 0 on each transfer and SHALL hold its final value from DONE until the next transfer.
REQ-014 Latency: the first idx_valid SHALL assert in the cycle after the transfer edge; with idx_ready held at 1, one index SHALL be reported per cycle.
REQ-015 With enable=0, no state, mask or count SHALL change, and outputs SHALL hold their values.
REQ-016 idx_valid, done and none_found SHALL be 0 outside EMIT or DONE as specified; no output SHALL be X after reset.

Reset
REQ-017 While reset=0, the block SHALL asynchronously force: state=IDLE, mask=0, match_count=0, idx_out=0, idx_valid=0, idx_last=0, done=0, none_found=0. flag_ready SHALL be 1 once reset is released.
REQ-018 Reset asserted mid-EMIT SHALL discard the vector; no done pulse SHALL follow.

Structure
REQ-019 Package string_match_pkg SHALL hold the N/M defaults, the state enum (IDLE, EMIT, DONE) and the IW/CW width functions.
REQ-020 The lowest-set-bit search SHALL be a separate combinational sub-module, match_prio_enc, which returns an index and a one-hot flag.

Verification
REQ-021 flag_in=16'b1000_0000_0000_1000 -> idx_out 0 (last=0), then 12 (last=1) on consecutive cycles; done with match_count=2, none_found=0.
REQ-022 flag_in=16'b0000_0000_0000_0111 -> no idx_valid; done and none_found pulse in the cycle after transfer; match_count=0.
REQ-023 flag_in=16'b1111_1111_1111_1000, idx_ready=1 -> indices 0..12 in 13 consecutive cycles, idx_last only on 12, match_count=13.
REQ-024 flag_in=16'b0010_0000_0100_0000, idx_ready low for 3 cycles -> idx_out=2 held stable for 3 cycles, then 9 with last=1; match_count=2.
REQ-025 reset driven low during EMIT of index 2 -> all outputs cleared immediately; flag_ready=1 after release; no done pulse.
REQ-026 enable=0 for 4 cycles during EMIT -> idx_out, match_count and state unchanged; reporting resumes unchanged when enable returns to 1.
